// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Types and constants shared by the RV32 hazard/bypass logic:
//               register index width, pipeline slot record, control mode.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int REG_W = 5;

    // x0 is hard-wired to zero and never a bypass source
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // Destination-register metadata carried by every pipeline slot
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             wb;
    } slot_t;

    // One control mode is chosen per cycle
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        FREEZE = 2'd3
    } mode_e;

    // A slot only writes the register file when it is real and targets rd != x0
    function automatic logic slot_writes(input slot_t s);
        return s.valid & s.wb & (s.rd != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its maximum value instead of
//               wrapping. Asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count increment requests, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Producer side of the operand-bypass interface for the 5-stage
//               RV32 pipeline. Tracks rd metadata through ID/EX, EX/MEM and
//               MEM/WB, detects load-use hazards (one bubble), services branch
//               flushes and freezes on data-memory wait. Keeps saturating
//               bubble and flush statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W = pipeline_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic [REG_W-1:0] id_ex_rs1,
    output logic [REG_W-1:0] id_ex_rs2,
    output logic [REG_W-1:0] ex_mem_rd,
    output logic             ex_mem_wb,
    output logic [REG_W-1:0] mem_wb_rd,
    output logic             mem_wb_wb,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import pipeline_pkg::*;

    // Bubbles carry all-zero fields so the forwarding unit never matches them
    localparam slot_t c_bubble = '{valid: 1'b0, rd: REG_ZERO, wb: 1'b0};

    // ID/EX slot: common slot record plus source indices and load flag
    slot_t            r_idex;
    logic [REG_W-1:0] r_idex_rs1;
    logic [REG_W-1:0] r_idex_rs2;
    logic             r_idex_mrd;

    slot_t            r_exmem;
    slot_t            r_memwb;

    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_lu;
    mode_e            w_mode;

    // A load in EX whose rd is read by the instruction in ID
    assign w_rs1_hit = id_use_rs1 & (id_rs1 == r_idex.rd);
    assign w_rs2_hit = id_use_rs2 & (id_rs2 == r_idex.rd);
    assign w_lu      = r_idex.valid & r_idex_mrd & (r_idex.rd != REG_ZERO)
                     & id_valid & (w_rs1_hit | w_rs2_hit);

    // Mode select: memory wait beats redirect beats load-use; idle in reset
    always_comb begin
        w_mode = NORMAL;
        if (!rst_n) begin
            w_mode = NORMAL;
        end else if (mem_busy) begin
            w_mode = FREEZE;
        end else if (ex_branch_taken) begin
            w_mode = FLUSH;
        end else if (w_lu) begin
            w_mode = STALL;
        end
    end

    assign stall_pc    = (w_mode == FREEZE) | (w_mode == STALL);
    assign stall_if_id = (w_mode == FREEZE) | (w_mode == STALL);
    assign flush_if_id = (w_mode == FLUSH);

    assign id_ex_rs1 = r_idex_rs1;
    assign id_ex_rs2 = r_idex_rs2;
    assign ex_mem_rd = r_exmem.rd;
    assign ex_mem_wb = slot_writes(r_exmem);
    assign mem_wb_rd = r_memwb.rd;
    assign mem_wb_wb = slot_writes(r_memwb);

    // Advance, bubble or hold the three slots according to the mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex     <= c_bubble;
            r_idex_rs1 <= '0;
            r_idex_rs2 <= '0;
            r_idex_mrd <= 1'b0;
            r_exmem    <= c_bubble;
            r_memwb    <= c_bubble;
        end else begin
            case (w_mode)
                FREEZE: begin
                    // Whole pipeline holds; a pending redirect waits in EX
                end
                FLUSH, STALL: begin
                    r_idex     <= c_bubble;
                    r_idex_rs1 <= '0;
                    r_idex_rs2 <= '0;
                    r_idex_mrd <= 1'b0;
                    r_exmem    <= r_idex;
                    r_memwb    <= r_exmem;
                end
                default: begin
                    r_idex.valid <= id_valid;
                    r_idex.rd    <= id_rd;
                    r_idex.wb    <= id_reg_write & id_valid;
                    r_idex_rs1   <= id_rs1;
                    r_idex_rs2   <= id_rs2;
                    r_idex_mrd   <= id_mem_read & id_valid;
                    r_exmem      <= r_idex;
                    r_memwb      <= r_exmem;
                end
            endcase
        end
    end

    sat_counter #(
        .W     (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_mode == STALL),
        .count (bubble_cnt)
    );

    sat_counter #(
        .W     (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_mode == FLUSH),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A queue-of-slots model
//               predicts every output each cycle; directed sequences add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs1 = '0;
    logic [REG_W-1:0] id_rs2 = '0;
    logic             id_use_rs1 = 1'b0;
    logic             id_use_rs2 = 1'b0;
    logic [REG_W-1:0] id_rd = '0;
    logic             id_reg_write = 1'b0;
    logic             id_mem_read = 1'b0;
    logic             ex_branch_taken = 1'b0;
    logic             mem_busy = 1'b0;
    logic             stall_pc, stall_if_id, flush_if_id;
    logic [REG_W-1:0] id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
    logic             ex_mem_wb, mem_wb_wb;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_W           (REG_W),
        .CNT_W           (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .flush_if_id     (flush_if_id),
        .id_ex_rs1       (id_ex_rs1),
        .id_ex_rs2       (id_ex_rs2),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_wb       (ex_mem_wb),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_wb       (mem_wb_wb),
        .bubble_cnt      (bubble_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pipe[0] = instruction in EX, pipe[1] = in MEM, pipe[2] = in WB
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        int rd;
        bit wb;
        bit ld;
    } mslot_t;

    mslot_t pipe[3];
    int     m_bub = 0;
    int     m_fl  = 0;

    function automatic bit m_hazard();
        if (!(pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && id_valid)) return 1'b0;
        return (id_use_rs1 && int'(id_rs1) == pipe[0].rd) ||
               (id_use_rs2 && int'(id_rs2) == pipe[0].rd);
    endfunction

    function automatic bit m_writes(input mslot_t s);
        return s.v && s.wb && s.rd != 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        mslot_t empty;
        bit     hz;
        empty = '{0, 0, 0, 0, 0, 0};
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = empty;
            m_bub = 0;
            m_fl  = 0;
        end else if (!mem_busy) begin
            hz = m_hazard();
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (ex_branch_taken) begin
                pipe[0] = empty;
                if (m_fl < CMAX) m_fl++;
            end else if (hz) begin
                pipe[0] = empty;
                if (m_bub < CMAX) m_bub++;
            end else begin
                pipe[0] = '{id_valid, int'(id_rs1), int'(id_rs2), int'(id_rd),
                            id_reg_write && id_valid, id_mem_read && id_valid};
            end
        end
    end

    // Compare every output against the model once per cycle
    always @(negedge clk) begin
        bit e_stall, e_flush;
        e_stall = rst_n && (mem_busy || (!ex_branch_taken && m_hazard()));
        e_flush = rst_n && !mem_busy && ex_branch_taken;
        check("m_stall_pc",    32'(stall_pc),    32'(e_stall));
        check("m_stall_if_id", 32'(stall_if_id), 32'(e_stall));
        check("m_flush_if_id", 32'(flush_if_id), 32'(e_flush));
        check("m_id_ex_rs1",   32'(id_ex_rs1),   32'(pipe[0].rs1));
        check("m_id_ex_rs2",   32'(id_ex_rs2),   32'(pipe[0].rs2));
        check("m_ex_mem_rd",   32'(ex_mem_rd),   32'(pipe[1].rd));
        check("m_ex_mem_wb",   32'(ex_mem_wb),   32'(m_writes(pipe[1])));
        check("m_mem_wb_rd",   32'(mem_wb_rd),   32'(pipe[2].rd));
        check("m_mem_wb_wb",   32'(mem_wb_wb),   32'(m_writes(pipe[2])));
        check("m_bubble_cnt",  32'(bubble_cnt),  32'(m_bub));
        check("m_flush_cnt",   32'(flush_cnt),   32'(m_fl));
    end

    // ---------------- directed stimulus ----------------
    // One cycle: apply ID-stage inputs after the edge, return at the negedge
    task automatic put(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit br, input bit busy);
        @(posedge clk);
        #1;
        id_valid        = v;
        id_rs1          = REG_W'(rs1);
        id_rs2          = REG_W'(rs2);
        id_use_rs1      = u1;
        id_use_rs2      = u2;
        id_rd           = REG_W'(rd);
        id_reg_write    = rw;
        id_mem_read     = mr;
        ex_branch_taken = br;
        mem_busy        = busy;
        @(negedge clk);
    endtask

    task automatic nop();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_stall_pc",   32'(stall_pc),   0);
        check("rst_ex_mem_rd",  32'(ex_mem_rd),  0);
        check("rst_bubble_cnt", 32'(bubble_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // add x5 then nops: rd reaches EX/MEM after 2 cycles, MEM/WB after 3
        put(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        nop();
        nop();
        check("add_ex_mem_rd", 32'(ex_mem_rd), 5);
        check("add_ex_mem_wb", 32'(ex_mem_wb), 1);
        nop();
        check("add_mem_wb_rd", 32'(mem_wb_rd), 5);
        check("add_mem_wb_wb", 32'(mem_wb_wb), 1);

        // lw x7 ; add x8, x7 -> one stall cycle
        put(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        put(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        check("lu_stall_pc",    32'(stall_pc),    1);
        check("lu_stall_if_id", 32'(stall_if_id), 1);
        put(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        check("lu_once",        32'(stall_pc),    0);
        check("lu_bubble_rs1",  32'(id_ex_rs1),   0);
        check("lu_load_in_mem", 32'(ex_mem_rd),   7);
        check("lu_bubble_cnt",  32'(bubble_cnt),  1);
        nop();
        check("lu_add_rs1",     32'(id_ex_rs1),   7);
        check("lu_load_in_wb",  32'(mem_wb_rd),   7);

        // rs1 matches but is not read; load to x0 -> no stall either
        put(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        put(1, 7, 0, 0, 0, 9, 1, 0, 0, 0);
        check("nouse_stall", 32'(stall_pc), 0);
        put(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        put(1, 0, 0, 1, 0, 9, 1, 0, 0, 0);
        check("x0_stall", 32'(stall_pc), 0);

        // Hazard via rs2
        put(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        put(1, 1, 3, 1, 1, 12, 1, 0, 0, 0);
        check("lu_rs2_stall", 32'(stall_pc), 1);
        put(1, 1, 3, 1, 1, 12, 1, 0, 0, 0);
        check("lu_rs2_cnt", 32'(bubble_cnt), 2);

        // Branch taken in the same cycle as a load-use: flush wins
        put(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        put(1, 4, 0, 1, 0, 13, 1, 0, 1, 0);
        check("fl_flush_if_id", 32'(flush_if_id), 1);
        check("fl_stall_pc",    32'(stall_pc),    0);
        nop();
        check("fl_flush_cnt",   32'(flush_cnt),   1);
        check("fl_bubble_cnt",  32'(bubble_cnt),  2);
        check("fl_bubble_rs1",  32'(id_ex_rs1),   0);
        check("fl_branch_adv",  32'(ex_mem_rd),   4);

        // Freeze for 3 cycles with a pending branch, then service it
        put(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        put(1, 1, 2, 1, 1, 11, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            put(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            check("fz_stall_pc",  32'(stall_pc),    1);
            check("fz_flush",     32'(flush_if_id), 0);
            check("fz_idex_rs1",  32'(id_ex_rs1),   1);
            check("fz_exmem_rd",  32'(ex_mem_rd),   6);
            check("fz_flush_cnt", 32'(flush_cnt),   1);
        end
        put(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("fz_release_flush", 32'(flush_if_id), 1);
        check("fz_release_stall", 32'(stall_pc),    0);
        nop();
        check("fz_flush_cnt2", 32'(flush_cnt), 2);
        check("fz_exmem_adv",  32'(ex_mem_rd), 11);
        check("fz_memwb_adv",  32'(mem_wb_rd), 6);

        // Saturation: 5 more load-use events, 2 more flushes (limit 3)
        for (int i = 0; i < 5; i++) begin
            put(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
            put(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
            put(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        end
        check("sat_bubble_cnt", 32'(bubble_cnt), 3);
        put(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        put(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        nop();
        check("sat_flush_cnt", 32'(flush_cnt), 3);

        // Asynchronous reset in the middle of a stall
        put(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        put(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        check("ar_pre_stall", 32'(stall_pc), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_stall_pc",    32'(stall_pc),    0);
        check("ar_stall_if_id", 32'(stall_if_id), 0);
        check("ar_bubble_cnt",  32'(bubble_cnt),  0);
        check("ar_flush_cnt",   32'(flush_cnt),   0);
        check("ar_ex_mem_rd",   32'(ex_mem_rd),   0);
        check("ar_mem_wb_rd",   32'(mem_wb_rd),   0);
        mem_busy = 1'b1;
        #1;
        check("ar_busy_masked", 32'(stall_pc), 0);
        @(posedge clk);
        #1;
        id_valid = 1'b0; id_rs1 = '0; id_use_rs1 = 1'b0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; mem_busy = 1'b0;
        rst_n = 1'b1;
        nop();
        check("post_rst_stall", 32'(stall_pc),  0);
        check("post_rst_rs1",   32'(id_ex_rs1), 0);
        nop();
        nop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
